// File: rtl/cva6_sv32_tlb.sv
// Fully-associative Sv32 TLB: combinational lookup, registered update/flush,
// tree-PLRU replacement, and raw tag/content images exported for formal checks.
module cva6_sv32_tlb #(
    parameter int TLB_ENTRIES = 4,
    parameter int ASID_WIDTH  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [62:0]           update_i,
    input  logic                  lu_access_i,
    input  logic [ASID_WIDTH-1:0] lu_asid_i,
    input  logic [31:0]           lu_vaddr_i,
    output logic [31:0]           lu_content_o,
    input  logic [ASID_WIDTH-1:0] asid_to_be_flushed_i,
    input  logic [31:0]           vaddr_to_be_flushed_i,
    output logic                  lu_is_4M_o,
    output logic                  lu_hit_o,
    output logic [127:0]          port_content_q_o,
    output logic [123:0]          port_tags_q_o
);

    localparam int LVLS = $clog2(TLB_ENTRIES);

    typedef struct packed {
        logic [8:0] asid;
        logic [9:0] vpn1;
        logic [9:0] vpn0;
        logic       is_4M;
        logic       valid;
    } tag_t;

    tag_t [TLB_ENTRIES-1:0]        tags_q, tags_d;
    logic [TLB_ENTRIES-1:0][31:0]  content_q, content_d;
    logic [TLB_ENTRIES-2:0]        plru_q, plru_d;

    logic [TLB_ENTRIES-1:0] lu_match, lu_first, victim_oh, write_oh;
    logic                   update_en;
    logic                   unused_offset;

    // The page offset never takes part in translation.
    assign unused_offset = ^lu_vaddr_i[11:0];

    function automatic logic vpn_match(input tag_t t, input logic [19:0] vpn);
        return (t.vpn1 == vpn[19:10]) && (t.is_4M || t.vpn0 == vpn[9:0]);
    endfunction

    // Point every tree node on the path to entry idx away from it.
    function automatic logic [TLB_ENTRIES-2:0] plru_touch(input logic [TLB_ENTRIES-2:0] tree,
                                                          input int idx);
        logic [TLB_ENTRIES-2:0] t;
        t = tree;
        for (int lvl = 0; lvl < LVLS; lvl++)
            for (int n = 0; n < TLB_ENTRIES - 1; n++)
                if (n == (1 << lvl) - 1 + (idx >> (LVLS - lvl)))
                    t[n] = ~1'((idx >> (LVLS - lvl - 1)) & 1);
        return t;
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        lu_match     = '0;
        lu_first     = '0;
        lu_content_o = '0;
        lu_is_4M_o   = 1'b0;
        for (int i = 0; i < TLB_ENTRIES; i++)
            lu_match[i] = tags_q[i].valid
                        && (tags_q[i].asid == 9'(lu_asid_i) || content_q[i][5])
                        && vpn_match(tags_q[i], lu_vaddr_i[31:12]);
        // Descending scan so the lowest-index match wins.
        for (int i = TLB_ENTRIES - 1; i >= 0; i--)
            if (lu_match[i]) begin
                lu_first     = '0;
                lu_first[i]  = 1'b1;
                lu_content_o = content_q[i];
                lu_is_4M_o   = tags_q[i].is_4M;
            end
    end

    assign lu_hit_o = |lu_match;

    always_comb begin
        logic en;
        logic found;
        victim_oh = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            en = 1'b1;
            for (int lvl = 0; lvl < LVLS; lvl++)
                for (int n = 0; n < TLB_ENTRIES - 1; n++)
                    if (n == (1 << lvl) - 1 + (i >> (LVLS - lvl)))
                        en = en & (plru_q[n] == 1'((i >> (LVLS - lvl - 1)) & 1));
            victim_oh[i] = en;
        end

        update_en = update_i[62] && !flush_i;
        write_oh  = '0;
        found     = 1'b0;
        for (int i = 0; i < TLB_ENTRIES; i++)
            if (!tags_q[i].valid && !found) begin
                write_oh[i] = 1'b1;
                found       = 1'b1;
            end
        if (!found)     write_oh = victim_oh;
        if (!update_en) write_oh = '0;
    end

    always_comb begin
        logic az, vz, vm, am, clr;
        tags_d    = tags_q;
        content_d = content_q;
        plru_d    = plru_q;
        az = (asid_to_be_flushed_i == '0);
        vz = (vaddr_to_be_flushed_i == '0);

        for (int i = 0; i < TLB_ENTRIES; i++) begin
            vm = vpn_match(tags_q[i], vaddr_to_be_flushed_i[31:12]);
            am = (tags_q[i].asid == 9'(asid_to_be_flushed_i)) && !content_q[i][5];
            if (az && vz)  clr = 1'b1;
            else if (az)   clr = vm;
            else if (vz)   clr = am;
            else           clr = vm && am;
            if (flush_i && clr) tags_d[i].valid = 1'b0;
        end

        for (int i = 0; i < TLB_ENTRIES; i++)
            if (lu_access_i && lu_first[i]) plru_d = plru_touch(plru_d, i);

        // A fresh write also becomes most-recently-used, overriding the lookup touch.
        for (int i = 0; i < TLB_ENTRIES; i++)
            if (write_oh[i]) begin
                tags_d[i]    = '{asid:  update_i[40:32], vpn1: update_i[60:51],
                                 vpn0:  update_i[50:41], is_4M: update_i[61], valid: 1'b1};
                content_d[i] = update_i[31:0];
                plru_d       = plru_touch(plru_d, i);
            end
    end

    // NOTE: the entry arrays are reset too, so the exported images read 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tags_q    <= '0;
            content_q <= '0;
            plru_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge state.
            tags_q    <= tags_d;
            content_q <= content_d;
            plru_q    <= plru_d;
        end
    end

    assign port_tags_q_o    = tags_q;
    assign port_content_q_o = content_q;

endmodule

// File: tb/tb_cva6_sv32_tlb.sv
// Directed self-checking bench for cva6_sv32_tlb: lookup, ASID/global, megapage,
// PLRU replacement, flush selectors, flush/update collision and async reset.
module tb_cva6_sv32_tlb;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         flush_i;
    logic [62:0]  update_i;
    logic         lu_access_i;
    logic [0:0]   lu_asid_i;
    logic [31:0]  lu_vaddr_i;
    logic [31:0]  lu_content_o;
    logic [0:0]   asid_to_be_flushed_i;
    logic [31:0]  vaddr_to_be_flushed_i;
    logic         lu_is_4M_o;
    logic         lu_hit_o;
    logic [127:0] port_content_q_o;
    logic [123:0] port_tags_q_o;

    int checks = 0;
    int errors = 0;

    cva6_sv32_tlb dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .flush_i              (flush_i),
        .update_i             (update_i),
        .lu_access_i          (lu_access_i),
        .lu_asid_i            (lu_asid_i),
        .lu_vaddr_i           (lu_vaddr_i),
        .lu_content_o         (lu_content_o),
        .asid_to_be_flushed_i (asid_to_be_flushed_i),
        .vaddr_to_be_flushed_i(vaddr_to_be_flushed_i),
        .lu_is_4M_o           (lu_is_4M_o),
        .lu_hit_o             (lu_hit_o),
        .port_content_q_o     (port_content_q_o),
        .port_tags_q_o        (port_tags_q_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [3:0] valid_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = port_tags_q_o[31*i];
        return v;
    endfunction

    task automatic lookup(input logic asid, input logic [31:0] va, input logic access);
        @(negedge clk_i);
        lu_asid_i   = asid;
        lu_vaddr_i  = va;
        lu_access_i = access;
        #1;
    endtask

    task automatic do_update(input logic is4m, input logic [19:0] vpn, input logic [8:0] asid,
                             input logic [31:0] content);
        @(negedge clk_i);
        lu_access_i = 1'b0;
        update_i    = {1'b1, is4m, vpn, asid, content};
        @(negedge clk_i);
        update_i    = '0;
    endtask

    task automatic do_flush(input logic asid, input logic [31:0] va);
        @(negedge clk_i);
        lu_access_i           = 1'b0;
        flush_i               = 1'b1;
        asid_to_be_flushed_i  = asid;
        vaddr_to_be_flushed_i = va;
        @(negedge clk_i);
        flush_i               = 1'b0;
        asid_to_be_flushed_i  = '0;
        vaddr_to_be_flushed_i = '0;
    endtask

    task automatic test_reset();
        lookup(1'b0, 32'h1234_5000, 1'b0);
        checks++; if (lu_hit_o !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", lu_hit_o); end
        checks++; if (lu_content_o !== 32'h0) begin errors++; $display("FAIL reset_content: got %h want 0", lu_content_o); end
        checks++; if (lu_is_4M_o !== 1'b0) begin errors++; $display("FAIL reset_is4m: got %b want 0", lu_is_4M_o); end
        checks++; if (port_tags_q_o !== 124'h0) begin errors++; $display("FAIL reset_tags: got %h want 0", port_tags_q_o); end
        checks++; if (port_content_q_o !== 128'h0) begin errors++; $display("FAIL reset_port_content: got %h want 0", port_content_q_o); end
    endtask

    task automatic test_basic_hit();
        do_update(1'b0, 20'h12345, 9'd1, 32'hDEAD_BE01);
        lookup(1'b1, 32'h1234_5ABC, 1'b0);
        checks++; if (lu_hit_o !== 1'b1) begin errors++; $display("FAIL basic_hit: got %b want 1", lu_hit_o); end
        checks++; if (lu_content_o !== 32'hDEAD_BE01) begin errors++; $display("FAIL basic_content: got %h want deadbe01", lu_content_o); end
        checks++; if (port_tags_q_o[30:0] !== {9'd1, 20'h12345, 1'b0, 1'b1}) begin errors++; $display("FAIL basic_tag0: got %h want %h", port_tags_q_o[30:0], {9'd1, 20'h12345, 1'b0, 1'b1}); end
        checks++; if (port_content_q_o[31:0] !== 32'hDEAD_BE01) begin errors++; $display("FAIL basic_port_content0: got %h want deadbe01", port_content_q_o[31:0]); end
        lookup(1'b1, 32'h1234_6000, 1'b0);
        checks++; if (lu_hit_o !== 1'b0) begin errors++; $display("FAIL basic_vpn_miss: got %b want 0", lu_hit_o); end
    endtask

    task automatic test_asid_global();
        lookup(1'b0, 32'h1234_5000, 1'b0);
        checks++; if (lu_hit_o !== 1'b0) begin errors++; $display("FAIL asid_miss: got %b want 0", lu_hit_o); end
        checks++; if (lu_content_o !== 32'h0) begin errors++; $display("FAIL asid_miss_content: got %h want 0", lu_content_o); end
        do_update(1'b0, 20'h12345, 9'd1, 32'h0000_0021);
        lookup(1'b0, 32'h1234_5000, 1'b0);
        checks++; if (lu_hit_o !== 1'b1) begin errors++; $display("FAIL global_hit: got %b want 1", lu_hit_o); end
        checks++; if (lu_content_o !== 32'h0000_0021) begin errors++; $display("FAIL global_content: got %h want 00000021", lu_content_o); end
        lookup(1'b1, 32'h1234_5000, 1'b0);
        checks++; if (lu_content_o !== 32'hDEAD_BE01) begin errors++; $display("FAIL lowest_index_wins: got %h want deadbe01", lu_content_o); end
    endtask

    task automatic test_megapage();
        do_update(1'b1, 20'h40000, 9'd0, 32'h0000_00CF);
        lookup(1'b0, 32'h400F_F000, 1'b0);
        checks++; if (lu_hit_o !== 1'b1) begin errors++; $display("FAIL mega_hit: got %b want 1", lu_hit_o); end
        checks++; if (lu_is_4M_o !== 1'b1) begin errors++; $display("FAIL mega_is4m: got %b want 1", lu_is_4M_o); end
        checks++; if (lu_content_o !== 32'h0000_00CF) begin errors++; $display("FAIL mega_content: got %h want 000000cf", lu_content_o); end
        lookup(1'b1, 32'h400F_F000, 1'b0);
        checks++; if (lu_hit_o !== 1'b0) begin errors++; $display("FAIL mega_asid_miss: got %b want 0", lu_hit_o); end
        lookup(1'b0, 32'h4040_0000, 1'b0);
        checks++; if (lu_hit_o !== 1'b0) begin errors++; $display("FAIL mega_vpn1_miss: got %b want 0", lu_hit_o); end
    endtask

    task automatic test_replacement();
        do_update(1'b0, 20'h00003, 9'd0, 32'h0000_0103);
        checks++; if (valid_vec() !== 4'b1111) begin errors++; $display("FAIL fill_valid: got %b want 1111", valid_vec()); end
        // Tree is all-zero here, so the victim is entry 0.
        do_update(1'b0, 20'h00005, 9'd0, 32'h0000_0105);
        checks++; if (port_tags_q_o[30:0] !== {9'd0, 20'h00005, 1'b0, 1'b1}) begin errors++; $display("FAIL victim_tag0: got %h want %h", port_tags_q_o[30:0], {9'd0, 20'h00005, 1'b0, 1'b1}); end
        checks++; if (port_content_q_o[31:0] !== 32'h0000_0105) begin errors++; $display("FAIL victim_content0: got %h want 00000105", port_content_q_o[31:0]); end
        checks++; if (valid_vec() !== 4'b1111) begin errors++; $display("FAIL victim_valid: got %b want 1111", valid_vec()); end
        lookup(1'b1, 32'h1234_5000, 1'b0);
        checks++; if (lu_content_o !== 32'h0000_0021) begin errors++; $display("FAIL victim_evicted: got %h want 00000021", lu_content_o); end
        // An accessed hit on entry 2 steers the next victim to entry 1.
        lookup(1'b0, 32'h4000_0000, 1'b1);
        checks++; if (lu_hit_o !== 1'b1) begin errors++; $display("FAIL access_hit: got %b want 1", lu_hit_o); end
        @(negedge clk_i);
        lu_access_i = 1'b0;
        do_update(1'b0, 20'h00006, 9'd0, 32'h0000_0106);
        checks++; if (port_tags_q_o[61:31] !== {9'd0, 20'h00006, 1'b0, 1'b1}) begin errors++; $display("FAIL access_victim_tag1: got %h want %h", port_tags_q_o[61:31], {9'd0, 20'h00006, 1'b0, 1'b1}); end
        checks++; if (port_content_q_o[63:32] !== 32'h0000_0106) begin errors++; $display("FAIL access_victim_content1: got %h want 00000106", port_content_q_o[63:32]); end
        checks++; if (port_content_q_o[95:64] !== 32'h0000_00CF) begin errors++; $display("FAIL access_entry2_kept: got %h want 000000cf", port_content_q_o[95:64]); end
    endtask

    task automatic test_flush();
        do_flush(1'b0, 32'h0);
        checks++; if (valid_vec() !== 4'b0000) begin errors++; $display("FAIL flush_all: got %b want 0000", valid_vec()); end
        do_update(1'b0, 20'h12345, 9'd1, 32'hDEAD_BE01);
        checks++; if (valid_vec() !== 4'b0001) begin errors++; $display("FAIL refill: got %b want 0001", valid_vec()); end

        @(negedge clk_i);
        flush_i               = 1'b1;
        asid_to_be_flushed_i  = 1'b1;
        vaddr_to_be_flushed_i = 32'h0077_7000;
        update_i              = {1'b1, 1'b0, 20'h00777, 9'd0, 32'h0000_0777};
        @(negedge clk_i);
        flush_i = 1'b0; asid_to_be_flushed_i = '0; vaddr_to_be_flushed_i = '0; update_i = '0;
        checks++; if (valid_vec() !== 4'b0001) begin errors++; $display("FAIL flush_drops_update: got %b want 0001", valid_vec()); end

        do_update(1'b0, 20'h00999, 9'd0, 32'h0000_0199);
        do_flush(1'b0, 32'h1234_5000);
        checks++; if (valid_vec() !== 4'b0010) begin errors++; $display("FAIL flush_vaddr: got %b want 0010", valid_vec()); end
        lookup(1'b1, 32'h1234_5000, 1'b0);
        checks++; if (lu_hit_o !== 1'b0) begin errors++; $display("FAIL flush_vaddr_lookup: got %b want 0", lu_hit_o); end

        do_update(1'b0, 20'h00AAA, 9'd1, 32'h0000_0021);
        do_update(1'b0, 20'h00BBB, 9'd1, 32'h0000_0001);
        checks++; if (valid_vec() !== 4'b0111) begin errors++; $display("FAIL asid_setup: got %b want 0111", valid_vec()); end
        do_flush(1'b1, 32'h0);
        checks++; if (valid_vec() !== 4'b0011) begin errors++; $display("FAIL flush_asid_keeps_global: got %b want 0011", valid_vec()); end
    endtask

    task automatic test_async_reset();
        lookup(1'b0, 32'h0099_9000, 1'b0);
        checks++; if (lu_content_o !== 32'h0000_0199) begin errors++; $display("FAIL pre_reset_content: got %h want 00000199", lu_content_o); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (port_tags_q_o !== 124'h0) begin errors++; $display("FAIL async_reset_tags: got %h want 0", port_tags_q_o); end
        checks++; if (port_content_q_o !== 128'h0) begin errors++; $display("FAIL async_reset_content: got %h want 0", port_content_q_o); end
        checks++; if (lu_hit_o !== 1'b0) begin errors++; $display("FAIL async_reset_hit: got %b want 0", lu_hit_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; update_i = '0; lu_access_i = 1'b0;
        lu_asid_i = '0; lu_vaddr_i = '0; asid_to_be_flushed_i = '0; vaddr_to_be_flushed_i = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        test_reset();
        test_basic_hit();
        test_asid_global();
        test_megapage();
        test_replacement();
        test_flush();
        test_async_reset();

        repeat (2) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
